controlador_transaccion: RTL and testbench
==========================================

Name: controlador_transaccion

Overview:
Sequences the transaction stage of the automatic cashier once the PIN stage reports a correct PIN. It latches the account balance and the transaction type (deposit or withdrawal), and accumulates the amount typed on the keypad as decimal digits. It then performs a single balance update cycle and signals dispense, insufficient funds and end of transaction. It sits between the PIN-reception block and the dispenser/balance storage.

Parameters:
BALANCE_W, 32, width of the balance register and of balance_inicial/balance.
MONTO_W, 32, width of the binary amount accumulator; must satisfy 2^MONTO_W > 10^MONTO_DIGITOS - 1.
MONTO_DIGITOS, 8, maximum number of decimal digits accepted for an amount.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
pin_ok  input  1  one-cycle pulse from the PIN stage: user authenticated, start transaction.
balance_inicial  input  BALANCE_W  account balance, sampled on pin_ok.
tipo_trans_stb  input  1  one-cycle strobe: tipo_trans valid.
tipo_trans  input  1  0 = deposit, 1 = withdrawal.
digito_stb  input  1  one-cycle strobe: digito valid.
digito  input  4  keypad digit, BCD.
monto_stb  input  1  one-cycle strobe: amount entry finished (enter key).
cancelar  input  1  abort the transaction.
balance  output  BALANCE_W  current balance register.
balance_actualizado  output  1  one-cycle pulse: balance changed.
entregar_dinero  output  1  one-cycle pulse: dispense the amount (withdrawal only).
fondos_insuficientes  output  1  one-cycle pulse: withdrawal rejected.
monto  output  MONTO_W  accumulated amount, binary.
ocupado  output  1  high in every state except IDLE.
fin  output  1  one-cycle pulse: transaction finished.

Behaviour:
- Reset (synchronous, dominant over all inputs): state IDLE; balance = 0; monto = 0; digit count = 0; tipo = 0; all pulse outputs = 0; ocupado = 0.
- States: IDLE, ESPERA_TIPO, RECIBIENDO_MONTO, CALCULANDO, FIN.
- IDLE:
  - On pin_ok: balance <= balance_inicial; next state ESPERA_TIPO.
  - All other strobes are ignored.
- ESPERA_TIPO:
  - On tipo_trans_stb: latch tipo; monto <= 0; count <= 0; next state RECIBIENDO_MONTO.
  - digito_stb and monto_stb are ignored.
- RECIBIENDO_MONTO:
  - On digito_stb with digito <= 9 and count < MONTO_DIGITOS: monto <= monto*10 + digito; count++.
  - A digit > 9, or a digit arriving when count == MONTO_DIGITOS, is ignored; monto and count are unchanged.
  - On monto_stb: next state CALCULANDO.
  - If digito_stb and monto_stb occur in the same cycle, the digit is accumulated first and included in the amount.
- CALCULANDO (exactly one cycle):
  - If monto == 0: no update and no pulses.
  - Deposit: balance <= balance + monto, saturating at 2^BALANCE_W - 1; pulse balance_actualizado.
  - Withdrawal with monto > balance: balance unchanged; pulse fondos_insuficientes.
  - Withdrawal with monto <= balance: balance <= balance - monto; pulse balance_actualizado and entregar_dinero in the same cycle.
  - Next state FIN.
- FIN: fin high for exactly one cycle; next state IDLE. monto holds its value until the next tipo_trans_stb.
- Latency:
  - monto_stb sampled at edge N → CALCULANDO during cycle N+1.
  - Result pulses and the updated balance are visible after edge N+1.
  - fin is high after edge N+2.
  - ocupado falls after edge N+3.
- cancelar:
  - In ESPERA_TIPO or RECIBIENDO_MONTO: go to FIN with no balance change and no result pulses; it has priority over every other strobe in the same cycle.
  - Ignored in IDLE, CALCULANDO and FIN.
- pin_ok outside IDLE is ignored; balance is not reloaded.
- Reset mid-operation: returns to IDLE in the following cycle; no fin pulse is emitted and all pulse outputs are cleared.
- All outputs are registered.

Decomposition:
- Shared package (cajero_pkg): state encoding constants, TIPO_DEPOSITO = 0, TIPO_RETIRO = 1, BCD_MAX = 9.
- One natural sub-module, acumulador_monto:
  - Inputs: clear, digito_stb, digito.
  - Holds the monto register and the digit counter, including the ×10 + digit step and the digit limit.
- The FSM and the balance arithmetic stay in controlador_transaccion.

Test Plan:
- Deposit: balance_inicial = 1000, pin_ok, tipo = 0, digits 2,5,0, monto_stb → monto = 250; balance = 1250; balance_actualizado pulses once; entregar_dinero stays 0; fin 1 cycle later.
- Withdrawal OK: balance_inicial = 1000, tipo = 1, digits 4,0,0 → balance = 600; balance_actualizado and entregar_dinero pulse together; then fin.
- Insufficient funds: balance_inicial = 100, tipo = 1, digits 1,0,1 → fondos_insuficientes pulses; balance stays 100; entregar_dinero = 0.
- Digit rules:
  - Digits 1,0xA,2 → monto = 12.
  - Nine digits of 9 with MONTO_DIGITOS = 8 → monto = 99999999.
  - digito_stb = 7 together with monto_stb after a prior 3 → monto = 37.
- Cancel and reset:
  - cancelar during RECIBIENDO_MONTO with monto = 55 → fin pulses; balance unchanged; no result pulses.
  - reset in RECIBIENDO_MONTO → IDLE next cycle; no fin.
- Saturation and ignored strobes:
  - balance_inicial = 0xFFFFFFF0, deposit 100 → balance = 0xFFFFFFFF.
  - pin_ok while ocupado → balance not reloaded.

Source files
------------

// File: rtl/cajero_pkg.sv
// Shared definitions for the cashier transaction stage: FSM state encoding,
// transaction type codes and BCD digit limits.
package cajero_pkg;

    typedef enum logic [2:0] {
        IDLE             = 3'd0,
        ESPERA_TIPO      = 3'd1,
        RECIBIENDO_MONTO = 3'd2,
        CALCULANDO       = 3'd3,
        FIN              = 3'd4
    } estado_t;

    localparam logic       TIPO_DEPOSITO = 1'b0;
    localparam logic       TIPO_RETIRO   = 1'b1;
    localparam logic [3:0] BCD_MAX       = 4'd9;

    function automatic logic digito_valido(input logic [3:0] d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/acumulador_monto.sv
// Decimal amount accumulator: converts keypad BCD digits into a binary amount,
// rejecting non-BCD codes and digits beyond the configured maximum count.
module acumulador_monto #(
    parameter int MONTO_W       = 32,
    parameter int MONTO_DIGITOS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               digito_stb,
    input  logic [3:0]         digito,
    output logic [MONTO_W-1:0] monto
);
    import cajero_pkg::*;

    localparam int CUENTA_W = $clog2(MONTO_DIGITOS + 1);

    logic [MONTO_W-1:0]  monto_r;
    logic [CUENTA_W-1:0] cuenta_r;
    logic                acepta_s;
    logic [MONTO_W-1:0]  siguiente_s;

    // Decide whether the incoming digit is taken and form monto*10 + digit.
    always_comb begin
        acepta_s    = 1'b0;
        siguiente_s = monto_r;
        if (digito_stb && digito_valido(digito) &&
            (cuenta_r < CUENTA_W'(MONTO_DIGITOS))) begin
            acepta_s    = 1'b1;
            siguiente_s = (monto_r << 3'd3) + (monto_r << 3'd1) + MONTO_W'(digito);
        end else begin
            acepta_s    = 1'b0;
            siguiente_s = monto_r;
        end
    end

    // Amount and digit-count registers; clear starts a fresh entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            monto_r  <= '0;
            cuenta_r <= '0;
        end else if (clear) begin
            monto_r  <= '0;
            cuenta_r <= '0;
        end else if (acepta_s) begin
            monto_r  <= siguiente_s;
            cuenta_r <= cuenta_r + CUENTA_W'(1);
        end else begin
            monto_r  <= monto_r;
            cuenta_r <= cuenta_r;
        end
    end

    assign monto = monto_r;

endmodule

// File: rtl/controlador_transaccion.sv
// Transaction sequencer for the cashier: latches balance and type after PIN
// approval, collects the amount, applies one balance update and reports it.
module controlador_transaccion #(
    parameter int BALANCE_W     = 32,
    parameter int MONTO_W       = 32,
    parameter int MONTO_DIGITOS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pin_ok,
    input  logic [BALANCE_W-1:0] balance_inicial,
    input  logic                 tipo_trans_stb,
    input  logic                 tipo_trans,
    input  logic                 digito_stb,
    input  logic [3:0]           digito,
    input  logic                 monto_stb,
    input  logic                 cancelar,
    output logic [BALANCE_W-1:0] balance,
    output logic                 balance_actualizado,
    output logic                 entregar_dinero,
    output logic                 fondos_insuficientes,
    output logic [MONTO_W-1:0]   monto,
    output logic                 ocupado,
    output logic                 fin
);
    import cajero_pkg::*;

    localparam int SUMA_W = ((BALANCE_W > MONTO_W) ? BALANCE_W : MONTO_W) + 1;

    estado_t              estado_r;
    logic [BALANCE_W-1:0] balance_r;
    logic                 tipo_r;
    logic                 actualizado_r;
    logic                 entregar_r;
    logic                 insuficiente_r;
    logic                 ocupado_r;
    logic                 fin_r;

    logic [MONTO_W-1:0]   monto_s;
    logic                 limpiar_s;
    logic                 digito_en_s;
    logic [SUMA_W-1:0]    balance_ext_s;
    logic [SUMA_W-1:0]    monto_ext_s;
    logic [SUMA_W-1:0]    suma_s;
    logic [BALANCE_W-1:0] deposito_s;
    logic [BALANCE_W-1:0] retiro_s;
    logic                 insuficiente_s;
    logic                 monto_cero_s;

    // Accumulator control: cancel always wins over type and digit strobes.
    always_comb begin
        limpiar_s   = 1'b0;
        digito_en_s = 1'b0;
        if (!cancelar) begin
            limpiar_s   = (estado_r == ESPERA_TIPO) && tipo_trans_stb;
            digito_en_s = (estado_r == RECIBIENDO_MONTO) && digito_stb;
        end else begin
            limpiar_s   = 1'b0;
            digito_en_s = 1'b0;
        end
    end

    acumulador_monto #(
        .MONTO_W       (MONTO_W),
        .MONTO_DIGITOS (MONTO_DIGITOS)
    ) u_acumulador (
        .clk        (clk),
        .reset      (reset),
        .clear      (limpiar_s),
        .digito_stb (digito_en_s),
        .digito     (digito),
        .monto      (monto_s)
    );

    // Balance arithmetic in a widened domain so carry and borrow are visible.
    always_comb begin
        balance_ext_s  = SUMA_W'(balance_r);
        monto_ext_s    = SUMA_W'(monto_s);
        suma_s         = balance_ext_s + monto_ext_s;
        insuficiente_s = (monto_ext_s > balance_ext_s);
        monto_cero_s   = (monto_s == '0);
        retiro_s       = BALANCE_W'(balance_ext_s - monto_ext_s);
        if (suma_s > SUMA_W'({BALANCE_W{1'b1}})) begin
            deposito_s = {BALANCE_W{1'b1}};
        end else begin
            deposito_s = BALANCE_W'(suma_s);
        end
    end

    // Transaction FSM with registered status and result pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_r       <= IDLE;
            balance_r      <= '0;
            tipo_r         <= TIPO_DEPOSITO;
            actualizado_r  <= 1'b0;
            entregar_r     <= 1'b0;
            insuficiente_r <= 1'b0;
            ocupado_r      <= 1'b0;
            fin_r          <= 1'b0;
        end else begin
            actualizado_r  <= 1'b0;
            entregar_r     <= 1'b0;
            insuficiente_r <= 1'b0;
            // Status trails the state by one edge so fin follows the FIN state.
            ocupado_r      <= (estado_r != IDLE);
            fin_r          <= (estado_r == FIN);
            case (estado_r)
                IDLE: begin
                    if (pin_ok) begin
                        balance_r <= balance_inicial;
                        estado_r  <= ESPERA_TIPO;
                    end
                end
                ESPERA_TIPO: begin
                    if (cancelar) begin
                        estado_r <= FIN;
                    end else if (tipo_trans_stb) begin
                        tipo_r   <= tipo_trans;
                        estado_r <= RECIBIENDO_MONTO;
                    end
                end
                RECIBIENDO_MONTO: begin
                    if (cancelar) begin
                        estado_r <= FIN;
                    end else if (monto_stb) begin
                        estado_r <= CALCULANDO;
                    end
                end
                CALCULANDO: begin
                    if (!monto_cero_s) begin
                        if (tipo_r == TIPO_DEPOSITO) begin
                            balance_r     <= deposito_s;
                            actualizado_r <= 1'b1;
                        end else if (insuficiente_s) begin
                            insuficiente_r <= 1'b1;
                        end else begin
                            balance_r     <= retiro_s;
                            actualizado_r <= 1'b1;
                            entregar_r    <= 1'b1;
                        end
                    end
                    estado_r <= FIN;
                end
                FIN: begin
                    estado_r <= IDLE;
                end
                default: begin
                    estado_r <= IDLE;
                end
            endcase
        end
    end

    assign balance              = balance_r;
    assign balance_actualizado  = actualizado_r;
    assign entregar_dinero      = entregar_r;
    assign fondos_insuficientes = insuficiente_r;
    assign monto                = monto_s;
    assign ocupado              = ocupado_r;
    assign fin                  = fin_r;

endmodule

// File: tb/tb_controlador_transaccion.sv
// Scoreboard bench for controlador_transaccion: each amount entry or cancel
// pushes its expected outcome, checked when the DUT raises fin.
module tb_controlador_transaccion;

    logic        clk = 1'b0;
    logic        reset;
    logic        pin_ok;
    logic [31:0] balance_inicial;
    logic        tipo_trans_stb;
    logic        tipo_trans;
    logic        digito_stb;
    logic [3:0]  digito;
    logic        monto_stb;
    logic        cancelar;
    logic [31:0] balance;
    logic        balance_actualizado;
    logic        entregar_dinero;
    logic        fondos_insuficientes;
    logic [31:0] monto;
    logic        ocupado;
    logic        fin;

    always #5 clk = ~clk;

    controlador_transaccion #(
        .BALANCE_W     (32),
        .MONTO_W       (32),
        .MONTO_DIGITOS (8)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .pin_ok               (pin_ok),
        .balance_inicial      (balance_inicial),
        .tipo_trans_stb       (tipo_trans_stb),
        .tipo_trans           (tipo_trans),
        .digito_stb           (digito_stb),
        .digito               (digito),
        .monto_stb            (monto_stb),
        .cancelar             (cancelar),
        .balance              (balance),
        .balance_actualizado  (balance_actualizado),
        .entregar_dinero      (entregar_dinero),
        .fondos_insuficientes (fondos_insuficientes),
        .monto                (monto),
        .ocupado              (ocupado),
        .fin                  (fin)
    );

    int n_pruebas = 0;
    int n_fallos  = 0;

    task automatic comprobar(input string tag, input logic [63:0] obs, input logic [63:0] esp);
        n_pruebas++;
        if (obs !== esp) begin
            n_fallos++;
            $display("FAIL %s: observado=%0h esperado=%0h", tag, obs, esp);
        end
    endtask

    typedef struct {
        logic [31:0] bal;
        logic [31:0] monto;
        int          act;
        int          ent;
        int          ins;
        string       tag;
    } esperado_t;

    esperado_t sb_q[$];
    int cnt_act = 0, cnt_ent = 0, cnt_ins = 0, fin_vistos = 0;

    // Monitor: counts result pulses and checks the scoreboard on each fin.
    always @(negedge clk) begin
        esperado_t e;
        if (reset) begin
            cnt_act = 0;
            cnt_ent = 0;
            cnt_ins = 0;
        end else begin
            if (balance_actualizado)  cnt_act++;
            if (entregar_dinero)      cnt_ent++;
            if (fondos_insuficientes) cnt_ins++;
            if (fin) begin
                fin_vistos++;
                if (sb_q.size() == 0) begin
                    comprobar("fin_inesperado", 64'(fin), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    comprobar({e.tag, "_balance"}, 64'(balance), 64'(e.bal));
                    comprobar({e.tag, "_monto"}, 64'(monto), 64'(e.monto));
                    comprobar({e.tag, "_n_actualizado"}, 64'(cnt_act), 64'(e.act));
                    comprobar({e.tag, "_n_entregar"}, 64'(cnt_ent), 64'(e.ent));
                    comprobar({e.tag, "_n_insuficiente"}, 64'(cnt_ins), 64'(e.ins));
                end
                cnt_act = 0;
                cnt_ent = 0;
                cnt_ins = 0;
            end
        end
    end

    logic [31:0] bal_m;
    logic [31:0] monto_m;
    int          cnt_m;
    logic        tipo_m;

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    task automatic iniciar(input logic [31:0] b);
        balance_inicial = b;
        pin_ok = 1'b1;
        ciclo();
        pin_ok = 1'b0;
        bal_m = b;
    endtask

    task automatic elegir_tipo(input logic t);
        tipo_trans = t;
        tipo_trans_stb = 1'b1;
        ciclo();
        tipo_trans_stb = 1'b0;
        tipo_m  = t;
        monto_m = 32'd0;
        cnt_m   = 0;
    endtask

    task automatic modelo_digito(input logic [3:0] d);
        if (d <= 4'd9 && cnt_m < 8) begin
            monto_m = monto_m * 32'd10 + 32'(d);
            cnt_m++;
        end
    endtask

    task automatic teclear(input logic [3:0] d);
        digito = d;
        digito_stb = 1'b1;
        ciclo();
        digito_stb = 1'b0;
        modelo_digito(d);
    endtask

    task automatic enviar_monto(input string tag, input logic con_digito, input logic [3:0] d);
        esperado_t e;
        logic [32:0] s;
        if (con_digito) begin
            digito = d;
            digito_stb = 1'b1;
            modelo_digito(d);
        end
        e.tag = tag; e.monto = monto_m; e.act = 0; e.ent = 0; e.ins = 0;
        if (monto_m != 32'd0) begin
            if (tipo_m == 1'b0) begin
                s = {1'b0, bal_m} + {1'b0, monto_m};
                bal_m = s[32] ? 32'hFFFF_FFFF : s[31:0];
                e.act = 1;
            end else if (monto_m > bal_m) begin
                e.ins = 1;
            end else begin
                bal_m = bal_m - monto_m;
                e.act = 1;
                e.ent = 1;
            end
        end
        e.bal = bal_m;
        sb_q.push_back(e);
        monto_stb = 1'b1;
        ciclo();
        monto_stb = 1'b0;
        digito_stb = 1'b0;
    endtask

    task automatic cancelar_tx(input string tag);
        esperado_t e;
        e.tag = tag; e.bal = bal_m; e.monto = monto_m; e.act = 0; e.ent = 0; e.ins = 0;
        sb_q.push_back(e);
        cancelar = 1'b1;
        ciclo();
        cancelar = 1'b0;
    endtask

    task automatic esperar_fin(input string tag, input int base);
        int k = 0;
        while (fin_vistos == base && k < 12) begin
            ciclo();
            k++;
        end
        comprobar({tag, "_fin_visto"}, 64'(fin_vistos), 64'(base + 1));
        ciclo();
        comprobar({tag, "_ocupado_bajo"}, 64'(ocupado), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulacion sin terminar");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset = 1'b1; pin_ok = 1'b0; balance_inicial = 32'd0;
        tipo_trans_stb = 1'b0; tipo_trans = 1'b0; digito_stb = 1'b0;
        digito = 4'd0; monto_stb = 1'b0; cancelar = 1'b0;
        bal_m = 32'd0; monto_m = 32'd0; cnt_m = 0; tipo_m = 1'b0;
        repeat (3) ciclo();
        comprobar("reset_balance", 64'(balance), 64'd0);
        comprobar("reset_monto", 64'(monto), 64'd0);
        comprobar("reset_ocupado", 64'(ocupado), 64'd0);
        comprobar("reset_fin", 64'(fin), 64'd0);
        comprobar("reset_pulsos", 64'({balance_actualizado, entregar_dinero, fondos_insuficientes}), 64'd0);
        reset = 1'b0;
        ciclo();

        // Deposit with explicit latency checks
        base = fin_vistos;
        iniciar(32'd1000);
        elegir_tipo(1'b0);
        comprobar("dep_ocupado", 64'(ocupado), 64'd1);
        comprobar("dep_balance_cargado", 64'(balance), 64'd1000);
        teclear(4'd2); teclear(4'd5); teclear(4'd0);
        enviar_monto("deposito", 1'b0, 4'd0);
        comprobar("dep_lat_n_sin_pulso", 64'(balance_actualizado), 64'd0);
        ciclo();
        comprobar("dep_lat_n1_act", 64'(balance_actualizado), 64'd1);
        comprobar("dep_lat_n1_entregar", 64'(entregar_dinero), 64'd0);
        comprobar("dep_lat_n1_balance", 64'(balance), 64'd1250);
        comprobar("dep_lat_n1_fin", 64'(fin), 64'd0);
        ciclo();
        comprobar("dep_lat_n2_fin", 64'(fin), 64'd1);
        comprobar("dep_lat_n2_ocupado", 64'(ocupado), 64'd1);
        ciclo();
        comprobar("dep_lat_n3_ocupado", 64'(ocupado), 64'd0);
        comprobar("dep_lat_n3_fin", 64'(fin), 64'd0);
        esperar_fin("deposito", base);

        base = fin_vistos;
        iniciar(32'd1000); elegir_tipo(1'b1);
        teclear(4'd4); teclear(4'd0); teclear(4'd0);
        enviar_monto("retiro_ok", 1'b0, 4'd0);
        esperar_fin("retiro_ok", base);

        base = fin_vistos;
        iniciar(32'd100); elegir_tipo(1'b1);
        teclear(4'd1); teclear(4'd0); teclear(4'd1);
        enviar_monto("insuficiente", 1'b0, 4'd0);
        esperar_fin("insuficiente", base);

        base = fin_vistos;
        iniciar(32'd0); elegir_tipo(1'b0);
        teclear(4'd1); teclear(4'hA); teclear(4'd2);
        enviar_monto("digito_invalido", 1'b0, 4'd0);
        esperar_fin("digito_invalido", base);

        base = fin_vistos;
        iniciar(32'd0); elegir_tipo(1'b0);
        for (int i = 0; i < 9; i++) teclear(4'd9);
        enviar_monto("limite_digitos", 1'b0, 4'd0);
        esperar_fin("limite_digitos", base);

        base = fin_vistos;
        iniciar(32'd0); elegir_tipo(1'b0);
        teclear(4'd3);
        enviar_monto("digito_con_enter", 1'b1, 4'd7);
        esperar_fin("digito_con_enter", base);

        base = fin_vistos;
        iniciar(32'd500); elegir_tipo(1'b1);
        enviar_monto("monto_cero", 1'b0, 4'd0);
        esperar_fin("monto_cero", base);

        base = fin_vistos;
        iniciar(32'd777); elegir_tipo(1'b1);
        teclear(4'd5); teclear(4'd5);
        cancelar_tx("cancelar");
        esperar_fin("cancelar", base);

        // Cancel outranks a simultaneous enter
        base = fin_vistos;
        iniciar(32'd300); elegir_tipo(1'b1);
        teclear(4'd1);
        monto_stb = 1'b1;
        cancelar_tx("cancelar_prioridad");
        monto_stb = 1'b0;
        esperar_fin("cancelar_prioridad", base);

        base = fin_vistos;
        iniciar(32'd400); elegir_tipo(1'b0);
        teclear(4'd5);
        reset = 1'b1;
        ciclo();
        reset = 1'b0;
        comprobar("reset_medio_ocupado", 64'(ocupado), 64'd0);
        comprobar("reset_medio_balance", 64'(balance), 64'd0);
        comprobar("reset_medio_monto", 64'(monto), 64'd0);
        repeat (5) ciclo();
        comprobar("reset_medio_sin_fin", 64'(fin_vistos), 64'(base));

        base = fin_vistos;
        iniciar(32'hFFFF_FFF0); elegir_tipo(1'b0);
        teclear(4'd1); teclear(4'd0); teclear(4'd0);
        enviar_monto("saturacion", 1'b0, 4'd0);
        esperar_fin("saturacion", base);

        base = fin_vistos;
        iniciar(32'd2000);
        balance_inicial = 32'd5;
        pin_ok = 1'b1;
        ciclo();
        pin_ok = 1'b0;
        comprobar("pin_ok_ignorado", 64'(balance), 64'd2000);
        elegir_tipo(1'b0);
        teclear(4'd1);
        enviar_monto("pin_ok_ocupado", 1'b0, 4'd0);
        esperar_fin("pin_ok_ocupado", base);

        comprobar("cola_vacia", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_pruebas, n_fallos);
        $finish;
    end

endmodule
